// File: rtl/binary_search_param_if.sv
// Search request/response bundle between a requester and binary_search_param,
// including the read port to the external synchronous RAM.
interface binary_search_param_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] A;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              f;
  logic              nf;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   probes;

  modport master (
    output start, mode, A, rd_data,
    input  rd_addr, busy, f, nf, addr, probes
  );

  modport slave (
    input  start, mode, A, rd_data,
    output rd_addr, busy, f, nf, addr, probes
  );
endinterface

// File: rtl/binary_search_param.sv
// Binary search over a sorted external synchronous RAM; exact-match or
// lower-bound mode, two cycles per probe (address issue, then compare).
//
// state | meaning
// IDLE  | waiting for start, result flags clear
// ISSUE | mid driven on rd_addr
// CMP   | rd_data valid for mid; narrow lo/hi or finish
// DONE  | result held until start drops
module binary_search_param #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  binary_search_param_if.slave bus
);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, CMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     lo_q, lo_d, hi_q, hi_d, probes_q, probes_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, addr_q, addr_d, cand_q, cand_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              mode_q, mode_d, valid_q, valid_d;
  logic              f_q, f_d, nf_q, nf_d;
  logic [PW:0]       sum;
  logic [PW-1:0]     mid;
  logic              hit, stop;

  // Sum is one bit wider than lo/hi so the midpoint never overflows.
  assign sum = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid = PW'(sum >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      probes_q  <= '0;
      rd_addr_q <= '0;
      addr_q    <= '0;
      cand_q    <= '0;
      a_q       <= '0;
      mode_q    <= 1'b0;
      valid_q   <= 1'b0;
      f_q       <= 1'b0;
      nf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      probes_q  <= probes_d;
      rd_addr_q <= rd_addr_d;
      addr_q    <= addr_d;
      cand_q    <= cand_d;
      a_q       <= a_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      f_q       <= f_d;
      nf_q      <= nf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    probes_d  = probes_q;
    rd_addr_d = rd_addr_q;
    addr_d    = addr_q;
    cand_d    = cand_q;
    a_d       = a_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    f_d       = f_q;
    nf_d      = nf_q;
    hit       = 1'b0;
    stop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.A;
          mode_d   = bus.mode;
          lo_d     = '0;
          hi_d     = PW'(DEPTH - 1);
          probes_d = '0;
          valid_d  = 1'b0;
          f_d      = 1'b0;
          nf_d     = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rd_addr_d = mid[ADDR_W-1:0];
        probes_d  = probes_q + 1'b1;
        state_d   = CMP;
      end
      CMP: begin
        if (!mode_q) begin
          if (bus.rd_data == a_q) begin
            hit    = 1'b1;
            addr_d = mid[ADDR_W-1:0];
            f_d    = 1'b1;
          end else if (bus.rd_data < a_q) begin
            lo_d = mid + 1'b1;
          end else if (mid == '0) begin
            stop = 1'b1;
          end else begin
            hi_d = mid - 1'b1;
          end
        end else begin
          if (bus.rd_data >= a_q) begin
            cand_d  = mid[ADDR_W-1:0];
            valid_d = 1'b1;
            if (mid == '0) stop = 1'b1;
            else           hi_d = mid - 1'b1;
          end else begin
            lo_d = mid + 1'b1;
          end
        end
        // A decrement at mid == 0 ends the search instead of wrapping hi.
        if (hit) begin
          state_d = DONE;
        end else if (stop || (lo_d > hi_d)) begin
          state_d = DONE;
          if (mode_q && valid_d) begin
            f_d    = 1'b1;
            addr_d = cand_d;
          end else begin
            nf_d = 1'b1;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (!bus.start) begin
          f_d     = 1'b0;
          nf_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_addr = (state_q == ISSUE) ? mid[ADDR_W-1:0] : rd_addr_q;
  assign bus.busy    = (state_q == ISSUE) || (state_q == CMP);
  assign bus.f       = f_q;
  assign bus.nf      = nf_q;
  assign bus.addr    = addr_q;
  assign bus.probes  = probes_q;
endmodule
